avr_regfile_multi: RTL and testbench

Parametrised AVR general-purpose register file. It provides two combinational read ports and one write port, and the write port can store an 8-bit byte or a 16-bit register pair (for ADIW/SBIW/MOVW/MUL results). The X/Y/Z pointer pairs are always visible on dedicated outputs. A handshaked debug dump engine lets the emulator-debugger stream out the whole register file without stalling the core. It sits between the decode/ALU stage and the debugger link.

---
 rtl/avr_regfile_pkg.sv | 14 +
 rtl/avr_regfile_dbg_dump.sv | 72 +++++++
 rtl/avr_regfile_multi.sv | 98 +++++++++
 tb/tb_avr_regfile_multi.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_regfile_pkg.sv
// rtl/avr_regfile_pkg.sv - shared types and constants for the AVR register file
package avr_regfile_pkg;

    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_SEND = 1'b1
    } dbg_state_e;

    // X/Y/Z low-byte positions, counted down from the top of the file
    localparam int PTR_X_OFS = 6;
    localparam int PTR_Y_OFS = 4;
    localparam int PTR_Z_OFS = 2;

endpackage

// File: rtl/avr_regfile_dbg_dump.sv
// rtl/avr_regfile_dbg_dump.sv - handshaked register dump FSM and index counter
module avr_regfile_dbg_dump
    import avr_regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_start,
    input  logic              dbg_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] dbg_index,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_busy,
    output logic              dbg_valid,
    output logic              dbg_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dbg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        done_d  = 1'b0;
        case (state_q)
            DBG_IDLE: begin
                if (dbg_start) begin
                    state_d = DBG_SEND;
                    index_d = '0;
                end
            end
            DBG_SEND: begin
                if (dbg_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DBG_IDLE;
                        index_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = DBG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DBG_IDLE;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    // Data is the live stored value; whatever is there on the accepting edge is reported
    assign dbg_data  = rd_data;
    assign dbg_index = index_q;
    assign dbg_busy  = (state_q == DBG_SEND);
    assign dbg_valid = (state_q == DBG_SEND);
    assign dbg_done  = done_q;

endmodule

// File: rtl/avr_regfile_multi.sv
// rtl/avr_regfile_multi.sv - AVR register file with byte/pair writes, pointer taps and debug dump
module avr_regfile_multi
    import avr_regfile_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   NUM_REGS = 32,
    parameter int   BYPASS   = 1,
    localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_word,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   wr_data_hi,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    input  logic [ADDR_W-1:0]   rd2_addr,
    output logic [DATA_W-1:0]   rd2_data,
    output logic [2*DATA_W-1:0] ptr_x,
    output logic [2*DATA_W-1:0] ptr_y,
    output logic [2*DATA_W-1:0] ptr_z,
    input  logic                dbg_start,
    output logic                dbg_busy,
    output logic                dbg_valid,
    input  logic                dbg_ready,
    output logic [ADDR_W-1:0]   dbg_index,
    output logic [DATA_W-1:0]   dbg_data,
    output logic                dbg_done
);

    localparam logic [ADDR_W-1:0] X_LO = ADDR_W'(NUM_REGS - PTR_X_OFS);
    localparam logic [ADDR_W-1:0] X_HI = ADDR_W'(NUM_REGS - PTR_X_OFS + 1);
    localparam logic [ADDR_W-1:0] Y_LO = ADDR_W'(NUM_REGS - PTR_Y_OFS);
    localparam logic [ADDR_W-1:0] Y_HI = ADDR_W'(NUM_REGS - PTR_Y_OFS + 1);
    localparam logic [ADDR_W-1:0] Z_LO = ADDR_W'(NUM_REGS - PTR_Z_OFS);
    localparam logic [ADDR_W-1:0] Z_HI = ADDR_W'(NUM_REGS - PTR_Z_OFS + 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [ADDR_W-1:0] pair_lo;
    logic [ADDR_W-1:0] pair_hi;
    logic [DATA_W-1:0] dbg_rd_data;

    assign pair_lo = {wr_addr[ADDR_W-1:1], 1'b0};
    assign pair_hi = {wr_addr[ADDR_W-1:1], 1'b1};

    // regs_d doubles as the bypass source: it already holds each incoming byte in place
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            if (wr_word) begin
                regs_d[pair_lo] = wr_data;
                regs_d[pair_hi] = wr_data_hi;
            end else begin
                regs_d[wr_addr] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1_data = (BYPASS != 0) ? regs_d[rd1_addr] : regs_q[rd1_addr];
    assign rd2_data = (BYPASS != 0) ? regs_d[rd2_addr] : regs_q[rd2_addr];

    assign ptr_x = {regs_q[X_HI], regs_q[X_LO]};
    assign ptr_y = {regs_q[Y_HI], regs_q[Y_LO]};
    assign ptr_z = {regs_q[Z_HI], regs_q[Z_LO]};

    assign dbg_rd_data = regs_q[dbg_index];

    avr_regfile_dbg_dump #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dbg_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg_start (dbg_start),
        .dbg_ready (dbg_ready),
        .rd_data   (dbg_rd_data),
        .dbg_index (dbg_index),
        .dbg_data  (dbg_data),
        .dbg_busy  (dbg_busy),
        .dbg_valid (dbg_valid),
        .dbg_done  (dbg_done)
    );

endmodule

// File: tb/tb_avr_regfile_multi.sv
// tb/tb_avr_regfile_multi.sv - self-checking bench for avr_regfile_multi
module tb_avr_regfile_multi;

    localparam int DW = 8;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_word;
    logic [AW-1:0] wr_addr, rd1_addr, rd2_addr;
    logic [DW-1:0] wr_data, wr_data_hi;
    logic          dbg_start, dbg_ready;

    logic [DW-1:0]   rd1_data, rd2_data, dbg_data;
    logic [2*DW-1:0] ptr_x, ptr_y, ptr_z;
    logic            dbg_busy, dbg_valid, dbg_done;
    logic [AW-1:0]   dbg_index;

    logic [DW-1:0]   rd1_b, rd2_b, dbg_data_b;
    logic [2*DW-1:0] ptr_x_b, ptr_y_b, ptr_z_b;
    logic            dbg_busy_b, dbg_valid_b, dbg_done_b;
    logic [AW-1:0]   dbg_index_b;

    always #5 clk = ~clk;

    avr_regfile_multi #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_word(wr_word), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_hi(wr_data_hi), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .rd2_addr(rd2_addr), .rd2_data(rd2_data), .ptr_x(ptr_x), .ptr_y(ptr_y), .ptr_z(ptr_z),
        .dbg_start(dbg_start), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_index(dbg_index), .dbg_data(dbg_data), .dbg_done(dbg_done)
    );

    avr_regfile_multi #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_word(wr_word), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_hi(wr_data_hi), .rd1_addr(rd1_addr), .rd1_data(rd1_b),
        .rd2_addr(rd2_addr), .rd2_data(rd2_b), .ptr_x(ptr_x_b), .ptr_y(ptr_y_b), .ptr_z(ptr_z_b),
        .dbg_start(dbg_start), .dbg_busy(dbg_busy_b), .dbg_valid(dbg_valid_b), .dbg_ready(dbg_ready),
        .dbg_index(dbg_index_b), .dbg_data(dbg_data_b), .dbg_done(dbg_done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] model [NR];
    int            beat_idx [$];
    logic [DW-1:0] beat_dat [$];
    logic [DW-1:0] beat_exp [$];
    int            done_cnt, done_cyc, last_beat_cyc, cyc;
    logic          busy_at_done;

    typedef struct {
        logic          we, ww;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, wh;
        logic [AW-1:0] r1, r2;
        logic [DW-1:0] e1, e2, e1n;
        logic [15:0]   ex, ey, ez;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_byp(input int a);
        if (wr_en && !wr_word && int'(wr_addr) == a) return wr_data;
        if (wr_en && wr_word && (int'(wr_addr) >> 1) == (a >> 1)) return (a % 2 == 1) ? wr_data_hi : wr_data;
        return model[a];
    endfunction

    function automatic logic [15:0] mptr(input int lo);
        return {model[lo + 1], model[lo]};
    endfunction

    // Sample handshake, advance one edge, then commit the model's view of the write
    task automatic tick();
        logic [DW-1:0] nxt [NR];
        #2;
        if (dbg_valid && dbg_ready) begin
            beat_idx.push_back(int'(dbg_index));
            beat_dat.push_back(dbg_data);
            beat_exp.push_back(model[dbg_index]);
            last_beat_cyc = cyc;
        end
        if (dbg_done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = dbg_busy;
        end
        nxt = model;
        if (rst_n && wr_en) begin
            if (wr_word) begin
                nxt[(int'(wr_addr) / 2) * 2]     = wr_data;
                nxt[(int'(wr_addr) / 2) * 2 + 1] = wr_data_hi;
            end else begin
                nxt[int'(wr_addr)] = wr_data;
            end
        end
        @(posedge clk);
        #1;
        model = nxt;
        cyc++;
    endtask

    task automatic clear_log();
        beat_idx.delete();
        beat_dat.delete();
        beat_exp.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_beat_cyc = -1;
        busy_at_done = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, stall;
        logic wrote, mid_start;

        rst_n = 1'b0; wr_en = 0; wr_word = 0; wr_addr = 0; wr_data = 0; wr_data_hi = 0;
        rd1_addr = 0; rd2_addr = 0; dbg_start = 0; dbg_ready = 0; cyc = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        for (int a = 0; a < NR; a++) begin
            rd1_addr = AW'(a);
            rd2_addr = AW'(NR - 1 - a);
            #1;
            chk("rst_rd1", 32'(rd1_data), 32'(0));
            chk("rst_rd2", 32'(rd2_data), 32'(0));
            chk("rst_rd1_nobyp", 32'(rd1_b), 32'(0));
        end
        chk("rst_ptr_x", 32'(ptr_x), 32'(0));
        chk("rst_ptr_y", 32'(ptr_y), 32'(0));
        chk("rst_ptr_z", 32'(ptr_z), 32'(0));
        chk("rst_busy", 32'(dbg_busy), 32'(0));
        chk("rst_valid", 32'(dbg_valid), 32'(0));
        chk("rst_done", 32'(dbg_done), 32'(0));
        chk("rst_index", 32'(dbg_index), 32'(0));
        chk("rst_busy_nobyp", 32'({dbg_busy_b, dbg_valid_b, dbg_done_b, dbg_index_b}), 32'(0));

        // hand-derived write/read vectors, applied in sequence from reset
        tbl[0] = '{1'b1, 1'b0, 5'd5,  8'hA7, 8'h00, 5'd5,  5'd5,  8'hA7, 8'hA7, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 5'd5,  5'd4,  8'hA7, 8'h00, 8'hA7, 16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 5'd27, 8'h34, 8'h12, 5'd26, 5'd27, 8'h34, 8'h12, 8'h00, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 5'd28, 5'd27, 8'h00, 8'h12, 8'h00, 16'h1234, 16'h0000, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 5'd28, 8'hFF, 8'hFF, 5'd28, 5'd29, 8'h00, 8'h00, 8'h00, 16'h1234, 16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 1'b1, 5'd30, 8'hCD, 8'hAB, 5'd31, 5'd30, 8'hAB, 8'hCD, 8'h00, 16'h1234, 16'h0000, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 5'd29, 8'h77, 8'h00, 5'd29, 5'd31, 8'h77, 8'hAB, 8'h00, 16'h1234, 16'h0000, 16'hABCD};
        tbl[7] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 5'd28, 5'd29, 8'h00, 8'h77, 8'h00, 16'h1234, 16'h7700, 16'hABCD};
        tbl[8] = '{1'b1, 1'b1, 5'd5,  8'h11, 8'h22, 5'd4,  5'd5,  8'h11, 8'h22, 8'h00, 16'h1234, 16'h7700, 16'hABCD};
        tbl[9] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00, 5'd4,  5'd5,  8'h11, 8'h22, 8'h11, 16'h1234, 16'h7700, 16'hABCD};
        for (int v = 0; v < 10; v++) begin
            wr_en = tbl[v].we; wr_word = tbl[v].ww; wr_addr = tbl[v].wa;
            wr_data = tbl[v].wd; wr_data_hi = tbl[v].wh;
            rd1_addr = tbl[v].r1; rd2_addr = tbl[v].r2;
            #1;
            chk($sformatf("vec%0d_rd1", v), 32'(rd1_data), 32'(tbl[v].e1));
            chk($sformatf("vec%0d_rd2", v), 32'(rd2_data), 32'(tbl[v].e2));
            chk($sformatf("vec%0d_rd1_nobyp", v), 32'(rd1_b), 32'(tbl[v].e1n));
            chk($sformatf("vec%0d_ptr_x", v), 32'(ptr_x), 32'(tbl[v].ex));
            chk($sformatf("vec%0d_ptr_y", v), 32'(ptr_y), 32'(tbl[v].ey));
            chk($sformatf("vec%0d_ptr_z", v), 32'(ptr_z), 32'(tbl[v].ez));
            tick();
        end
        wr_en = 0; wr_word = 0;

        // randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_word = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, NR - 1));
            wr_data = DW'($urandom);
            wr_data_hi = DW'($urandom);
            rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
            rd2_addr = ($urandom_range(0, 3) == 0) ? (wr_addr ^ AW'(1)) : AW'($urandom_range(0, NR - 1));
            #1;
            chk("rnd_rd1", 32'(rd1_data), 32'(exp_byp(int'(rd1_addr))));
            chk("rnd_rd2", 32'(rd2_data), 32'(exp_byp(int'(rd2_addr))));
            chk("rnd_rd1_nobyp", 32'(rd1_b), 32'(model[rd1_addr]));
            chk("rnd_rd2_nobyp", 32'(rd2_b), 32'(model[rd2_addr]));
            chk("rnd_ptr_x", 32'(ptr_x), 32'(mptr(NR - 6)));
            chk("rnd_ptr_y", 32'(ptr_y), 32'(mptr(NR - 4)));
            chk("rnd_ptr_z", 32'(ptr_z), 32'(mptr(NR - 2)));
            chk("rnd_ptr_x_nobyp", 32'(ptr_x_b), 32'(mptr(NR - 6)));
            chk("rnd_ptr_y_nobyp", 32'(ptr_y_b), 32'(mptr(NR - 4)));
            chk("rnd_ptr_z_nobyp", 32'(ptr_z_b), 32'(mptr(NR - 2)));
            tick();
        end

        // full dump with ready held high
        wr_word = 0;
        for (int i = 0; i < NR; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(8'h40 + i);
            tick();
        end
        wr_en = 0;
        clear_log();
        dbg_ready = 1; dbg_start = 1;
        tick();
        dbg_start = 0;
        k = 0;
        while (done_cnt == 0 && k < 200) begin tick(); k++; end
        chk("dump1_done_seen", 32'(done_cnt), 32'(1));
        chk("dump1_beats", 32'(beat_idx.size()), 32'(NR));
        for (int i = 0; i < NR && i < beat_idx.size(); i++) begin
            chk($sformatf("dump1_idx%0d", i), 32'(beat_idx[i]), 32'(i));
            chk($sformatf("dump1_dat%0d", i), 32'(beat_dat[i]), 32'(8'h40 + i));
        end
        chk("dump1_done_after_last", 32'(done_cyc), 32'(last_beat_cyc + 1));
        chk("dump1_busy_at_done", 32'(busy_at_done), 32'(0));
        repeat (3) tick();
        chk("dump1_single_done", 32'(done_cnt), 32'(1));
        chk("dump1_idle_busy", 32'(dbg_busy), 32'(0));
        chk("dump1_idle_index", 32'(dbg_index), 32'(0));

        // stalled dump: toggling ready, write while beat 3 waits, ignored restart
        clear_log();
        dbg_start = 1;
        tick();
        dbg_start = 0;
        stall = 0; wrote = 0; mid_start = 0; k = 0;
        while (done_cnt == 0 && k < 400) begin
            dbg_ready = (k % 2 == 0);
            dbg_start = 0;
            if (dbg_valid && dbg_index == AW'(3) && !wrote) begin
                dbg_ready = 0;
                if (stall == 1) begin wr_en = 1; wr_word = 0; wr_addr = 3; wr_data = 8'hEE; end
                stall++;
                if (stall == 3) wrote = 1;
            end
            if (dbg_valid && dbg_index == AW'(10) && !mid_start) begin
                dbg_start = 1; mid_start = 1;
            end
            tick();
            wr_en = 0;
            k++;
        end
        dbg_start = 0; dbg_ready = 1;
        repeat (5) tick();
        chk("dump2_beats", 32'(beat_idx.size()), 32'(NR));
        for (int i = 0; i < NR && i < beat_idx.size(); i++) begin
            chk($sformatf("dump2_idx%0d", i), 32'(beat_idx[i]), 32'(i));
            chk($sformatf("dump2_dat%0d", i), 32'(beat_dat[i]), 32'(beat_exp[i]));
        end
        if (beat_dat.size() > 3) chk("dump2_beat3_live", 32'(beat_dat[3]), 32'(8'hEE));
        else chk("dump2_beat3_present", 32'(beat_dat.size()), 32'(4));
        chk("dump2_single_done", 32'(done_cnt), 32'(1));
        chk("dump2_idle_busy", 32'(dbg_busy), 32'(0));

        // dbg_start coincident with dbg_done starts a new dump
        clear_log();
        dbg_ready = 1; dbg_start = 1;
        tick();
        dbg_start = 0;
        k = 0;
        while (!dbg_done && k < 100) begin tick(); k++; end
        chk("back2back_done_seen", 32'(dbg_done), 32'(1));
        dbg_start = 1;
        tick();
        dbg_start = 0;
        chk("back2back_busy", 32'(dbg_busy), 32'(1));
        chk("back2back_valid", 32'(dbg_valid), 32'(1));
        chk("back2back_index", 32'(dbg_index), 32'(0));

        // reset in mid-dump
        k = 0;
        while (dbg_index != AW'(10) && k < 100) begin tick(); k++; end
        chk("abort_reached_idx10", 32'(dbg_index), 32'(10));
        rst_n = 0;
        #1;
        chk("abort_valid", 32'(dbg_valid), 32'(0));
        chk("abort_busy", 32'(dbg_busy), 32'(0));
        chk("abort_done", 32'(dbg_done), 32'(0));
        chk("abort_index", 32'(dbg_index), 32'(0));
        for (int a = 0; a < NR; a++) begin
            rd1_addr = AW'(a);
            #1;
            chk("abort_rd1_zero", 32'(rd1_data), 32'(0));
            chk("abort_rd1_zero_nobyp", 32'(rd1_b), 32'(0));
        end
        chk("abort_ptrs", 32'({ptr_x, ptr_y}), 32'(0));
        chk("abort_ptr_z", 32'(ptr_z), 32'(0));
        for (int i = 0; i < NR; i++) model[i] = '0;
        clear_log();
        tick();
        tick();
        rst_n = 1;
        repeat (40) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(0));
        chk("abort_no_beats", 32'(beat_idx.size()), 32'(0));
        chk("abort_stays_idle", 32'(dbg_busy), 32'(0));
        chk("abort_dut0_idle", 32'({dbg_busy_b, dbg_valid_b, dbg_done_b}), 32'(0));
        chk("abort_dut0_data", 32'({dbg_index_b, dbg_data_b, rd2_b}), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
